// File: rtl/masked_sbox_input_stage.sv
// masked_sbox_input_stage
//
// Entry stage of the 3-share (second-order) masked AES S-box inversion
// pipeline. Each byte share x_i is split into GF(16) nibbles
// (b_i = high, c_i = low). The stage produces shares of
//   d = NU*b^2 ^ b*c ^ c^2
// which feed the GF(16) inverter. It also forwards the b/c shares,
// delayed so that they line up with d.
//
// Pipeline: two register stages, one operation per cycle, latency 2 en-cycles.
//   stage 1: per-domain inner terms L_i, six refreshed cross products P_ij,
//            copies of b_i/c_i and the valid bit
//   stage 2: d_i = L_i ^ P_ij ^ P_ik, delayed b/c shares and out_valid
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   en              pipeline advance (0 freezes every register)
//   in_valid        x1..x3 and r carry a valid operation
//   x1, x2, x3      8-bit byte shares
//   r               fresh randomness {r2, r1, r0}, 4 bits each
//   out_valid       d/b/c outputs carry a valid result
//   d1, d2, d3      shares of d
//   b1..b3, c1..c3  high/low nibble shares aligned with d
//
// Masking note: domain i's inner term uses only b_i and c_i. Every cross
// product b_i*c_j mixes two domains, so it is masked with fresh randomness
// and registered on its own before anything recombines it. The stage-1
// registers are the glitch barrier. They must survive synthesis, so keep
// this module's hierarchy intact.

module masked_sbox_input_stage #(
  parameter logic [3:0] NU = 4'h8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  input  logic [7:0]  x1,
  input  logic [7:0]  x2,
  input  logic [7:0]  x3,
  input  logic [11:0] r,
  output logic        out_valid,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic [3:0]  b1,
  output logic [3:0]  b2,
  output logic [3:0]  b3,
  output logic [3:0]  c1,
  output logic [3:0]  c2,
  output logic [3:0]  c3
);

  // GF(16) multiply in polynomial basis, modulus x^4 + x + 1.
  // Take the carry-less product, then fold x^4, x^5 and x^6 back in:
  // x^4 = x+1, x^5 = x^2+x, x^6 = x^3+x^2.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ ({3'b000, a} << i);
    end
    return p[3:0]
         ^ (p[4] ? 4'h3 : 4'h0)
         ^ (p[5] ? 4'h6 : 4'h0)
         ^ (p[6] ? 4'hC : 4'h0);
  endfunction

  // Nibble split, one entry per share domain.
  logic [3:0] b_in [3];
  logic [3:0] c_in [3];

  assign b_in[0] = x1[7:4];
  assign b_in[1] = x2[7:4];
  assign b_in[2] = x3[7:4];
  assign c_in[0] = x1[3:0];
  assign c_in[1] = x2[3:0];
  assign c_in[2] = x3[3:0];

  // Stage-1 state.
  logic [3:0] l_d [3];
  logic [3:0] l_q [3];
  // Cross terms: index 0..5 = P12, P21, P13, P31, P23, P32.
  logic [3:0] p_d [6];
  logic [3:0] p_q [6];
  logic [3:0] b_s1_d [3];
  logic [3:0] b_s1_q [3];
  logic [3:0] c_s1_d [3];
  logic [3:0] c_s1_q [3];
  logic       v1_d;
  logic       v1_q;

  // Stage-2 state.
  logic [3:0] d_d [3];
  logic [3:0] d_q [3];
  logic [3:0] b_s2_d [3];
  logic [3:0] b_s2_q [3];
  logic [3:0] c_s2_d [3];
  logic [3:0] c_s2_q [3];
  logic       v2_d;
  logic       v2_q;

  always_comb begin
    // Inner terms: each one depends only on its own domain.
    for (int i = 0; i < 3; i++) begin
      l_d[i] = gf16_mul(NU, gf16_mul(b_in[i], b_in[i]))
             ^ gf16_mul(c_in[i], c_in[i])
             ^ gf16_mul(b_in[i], c_in[i]);
      b_s1_d[i] = b_in[i];
      c_s1_d[i] = c_in[i];
    end

    // Each pair of mirrored cross products shares one random nibble.
    // The mask cancels only after both halves land in different d shares.
    p_d[0] = gf16_mul(b_in[0], c_in[1]) ^ r[3:0];   // P12
    p_d[1] = gf16_mul(b_in[1], c_in[0]) ^ r[3:0];   // P21
    p_d[2] = gf16_mul(b_in[0], c_in[2]) ^ r[7:4];   // P13
    p_d[3] = gf16_mul(b_in[2], c_in[0]) ^ r[7:4];   // P31
    p_d[4] = gf16_mul(b_in[1], c_in[2]) ^ r[11:8];  // P23
    p_d[5] = gf16_mul(b_in[2], c_in[1]) ^ r[11:8];  // P32
    v1_d   = in_valid;

    // Recombination reads only registered terms.
    d_d[0] = l_q[0] ^ p_q[0] ^ p_q[2];
    d_d[1] = l_q[1] ^ p_q[1] ^ p_q[4];
    d_d[2] = l_q[2] ^ p_q[3] ^ p_q[5];
    for (int i = 0; i < 3; i++) begin
      b_s2_d[i] = b_s1_q[i];
      c_s2_d[i] = c_s1_q[i];
    end
    v2_d = v1_q;
  end

  // Datapath registers keep loading when in_valid=0, so a bubble simply
  // travels down the pipe with its valid bit cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        l_q[i]    <= 4'h0;
        b_s1_q[i] <= 4'h0;
        c_s1_q[i] <= 4'h0;
        d_q[i]    <= 4'h0;
        b_s2_q[i] <= 4'h0;
        c_s2_q[i] <= 4'h0;
      end
      for (int k = 0; k < 6; k++) begin
        p_q[k] <= 4'h0;
      end
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < 3; i++) begin
        l_q[i]    <= l_d[i];
        b_s1_q[i] <= b_s1_d[i];
        c_s1_q[i] <= c_s1_d[i];
        d_q[i]    <= d_d[i];
        b_s2_q[i] <= b_s2_d[i];
        c_s2_q[i] <= c_s2_d[i];
      end
      for (int k = 0; k < 6; k++) begin
        p_q[k] <= p_d[k];
      end
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign out_valid = v2_q;
  assign d1 = d_q[0];
  assign d2 = d_q[1];
  assign d3 = d_q[2];
  assign b1 = b_s2_q[0];
  assign b2 = b_s2_q[1];
  assign b3 = b_s2_q[2];
  assign c1 = c_s2_q[0];
  assign c2 = c_s2_q[1];
  assign c3 = c_s2_q[2];

endmodule

// File: tb/tb_masked_sbox_input_stage.sv
// Testbench for masked_sbox_input_stage.
// A GF(16) reference model computes expected d values. A scoreboard queue
// holds one expected record per accepted operation, and each record is
// popped when out_valid is seen. A reference valid pipeline checks
// out_valid on every cycle.

module tb_masked_sbox_input_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  x1 = 8'h00;
  logic [7:0]  x2 = 8'h00;
  logic [7:0]  x3 = 8'h00;
  logic [11:0] r = 12'h000;
  logic        out_valid;
  logic [3:0]  d1, d2, d3, b1, b2, b3, c1, c2, c3;

  masked_sbox_input_stage #(.NU(4'h8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .x1(x1), .x2(x2), .x3(x3), .r(r),
    .out_valid(out_valid),
    .d1(d1), .d2(d2), .d3(d3),
    .b1(b1), .b2(b2), .b3(b3),
    .c1(c1), .c2(c2), .c3(c3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [3:0] b1, b2, b3, c1, c2, c3;
  } exp_t;

  typedef struct {
    logic [7:0] x;      // unmasked byte
    logic [3:0] exp_d;  // required d
    bit         rnd;    // random split and r, else (x,0,0) with r=0
  } vec_t;

  exp_t       sb[$];
  logic [1:0] vpipe = 2'b00;
  logic [3:0] cur_d = 4'h0;
  bit         chk_on = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  // Shift-and-reduce reference multiply (x^4 = x + 1).
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] ref_d(input logic [7:0] x);
    logic [3:0] b;
    logic [3:0] c;
    b = x[7:4];
    c = x[3:0];
    return ref_mul(4'h8, ref_mul(b, b)) ^ ref_mul(b, c) ^ ref_mul(c, c);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, check 1 ns later.
  task automatic step(input logic e, input logic v, input logic [7:0] a1,
                      input logic [7:0] a2, input logic [7:0] a3,
                      input logic [11:0] rr, input logic [3:0] ed);
    exp_t rec;
    @(negedge clk);
    en = e; in_valid = v; x1 = a1; x2 = a2; x3 = a3; r = rr; cur_d = ed;
    @(posedge clk);
    if (!rst_n) begin
      vpipe = 2'b00;
      sb.delete();
    end else if (en) begin
      if (in_valid) begin
        rec.d  = cur_d;
        rec.b1 = x1[7:4]; rec.b2 = x2[7:4]; rec.b3 = x3[7:4];
        rec.c1 = x1[3:0]; rec.c2 = x2[3:0]; rec.c3 = x3[3:0];
        sb.push_back(rec);
      end
      vpipe = {vpipe[0], in_valid};
    end
    #1;
    if (chk_on && rst_n) begin
      check("out_valid", 64'(out_valid), 64'(vpipe[1]));
      if (vpipe[1] && out_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: out_valid with no expected entry");
        end else begin
          rec = sb.pop_front();
          check("d_xor", 64'(d1 ^ d2 ^ d3), 64'(rec.d));
          check("b_shares", 64'({b1, b2, b3}), 64'({rec.b1, rec.b2, rec.b3}));
          check("c_shares", 64'({c1, c2, c3}), 64'({rec.c1, rec.c2, rec.c3}));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 12'h000, 4'h0);
  endtask

  task automatic op(input logic [7:0] val, input logic [3:0] ed, input bit rnd);
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [11:0] rr;
    if (rnd) begin
      s1 = 8'($urandom);
      s2 = 8'($urandom);
      rr = 12'($urandom);
    end else begin
      s1 = 8'h00;
      s2 = 8'h00;
      rr = 12'h000;
    end
    step(1'b1, 1'b1, val ^ s1 ^ s2, s1, s2, rr, ed);
  endtask

  vec_t vecs[7];
  logic [39:0] snap;

  initial begin
    vecs[0] = '{x: 8'h53, exp_d: 4'h9, rnd: 1'b0};
    vecs[1] = '{x: 8'h10, exp_d: 4'h8, rnd: 1'b1};
    vecs[2] = '{x: 8'h01, exp_d: 4'h1, rnd: 1'b1};
    vecs[3] = '{x: 8'h00, exp_d: 4'h0, rnd: 1'b1};
    vecs[4] = '{x: 8'hFF, exp_d: 4'hF, rnd: 1'b1};
    vecs[5] = '{x: 8'h11, exp_d: 4'h8, rnd: 1'b1};
    vecs[6] = '{x: 8'h20, exp_d: 4'h6, rnd: 1'b1};

    // Power-on reset.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 12'h000, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    check("reset_state", 64'({out_valid, d1, d2, d3, b1, b2, b3, c1, c2, c3}), 64'd0);

    // Table vectors, back to back.
    for (int i = 0; i < 7; i++) begin
      op(vecs[i].x, vecs[i].exp_d, vecs[i].rnd);
      $display("[TB] vector x=%02h expect d=%0h", vecs[i].x, vecs[i].exp_d);
    end
    idle(2);

    // Exhaustive sweep, streamed back to back.
    for (int v = 0; v < 256; v++) op(8'(v), ref_d(8'(v)), 1'b1);
    idle(2);
    $display("[TB] sweep of 256 bytes streamed");

    // Bubbles: alternating in_valid.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] bv;
      bv = 8'($urandom);
      if (i % 2 == 0) op(bv, ref_d(bv), 1'b1);
      else step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 12'($urandom), 4'h0);
    end
    idle(2);
    $display("[TB] bubble sequence done");

    // Stall: a valid op sits in stage 1 while en=0 for 3 cycles.
    idle(1);
    op(8'hA7, ref_d(8'hA7), 1'b1);
    snap = {out_valid, d1, d2, d3, b1, b2, b3, c1, c2, c3};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 12'($urandom), 4'hF);
      check("stall_hold", 64'({out_valid, d1, d2, d3, b1, b2, b3, c1, c2, c3}), 64'(snap));
    end
    idle(1);  // second en-cycle: result of A7 checked here
    check("stall_result_valid", 64'(out_valid), 64'd1);
    idle(2);
    $display("[TB] stall sequence done");

    // Mid-stream asynchronous reset: one op at the output, one in stage 1.
    op(8'h53, 4'h9, 1'b1);
    op(8'h3C, ref_d(8'h3C), 1'b1);
    @(negedge clk);
    en = 1'b1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'd0);
    check("async_reset_data", 64'({d1, d2, d3, b1, b2, b3, c1, c2, c3}), 64'd0);
    sb.delete();
    vpipe = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);  // no spurious out_valid may appear
    op(8'h01, 4'h1, 1'b1);
    idle(2);
    $display("[TB] reset sequence done");

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/masked_sbox_input_stage.md
Name: masked_sbox_input_stage

Overview:
- Entry stage of the second-order (3-share) masked AES S-box inversion pipeline; the mirror of the final stage that recombines the GF(16) inverse into output byte shares.
- Splits each 8-bit byte share into GF(16) nibbles: b = high nibble, c = low nibble.
- Computes shares of d = nu*b^2 xor b*c xor c^2, the GF(16) element passed to the inverter.
- Forwards b and c shares, aligned to d, for use by the downstream multiply stages.

Parameters:
- NU, 4'h8, GF(16) norm constant in d. Fixed for the AES tower field; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  pipeline advance; 0 freezes all registers
- in_valid  input  1  x1..x3 and r hold a valid operation
- x1  input  8  byte share 1
- x2  input  8  byte share 2
- x3  input  8  byte share 3
- r  input  12  fresh randomness {r2,r1,r0}, 4 bits each, uniform per valid input
- out_valid  output  1  d/b/c outputs hold a valid result
- d1  output  4  d share 1
- d2  output  4  d share 2
- d3  output  4  d share 3
- b1  output  4  high-nibble share 1, delayed to align with d
- b2  output  4  high-nibble share 2, delayed to align with d
- b3  output  4  high-nibble share 3, delayed to align with d
- c1  output  4  low-nibble share 1, delayed to align with d
- c2  output  4  low-nibble share 2, delayed to align with d
- c3  output  4  low-nibble share 3, delayed to align with d

Behaviour:
- Field and nibble split:
  - GF(16) uses polynomial basis, x^4+x+1.
  - b_i = x_i[7:4], c_i = x_i[3:0].
- Share domains:
  - Domain i uses only b_i, c_i and the randomness assigned to it.
  - Share wires never combine two domains without a register in between.
- Stage 1 (registered when en=1):
  - Inner terms: L_i = NU*b_i^2 xor c_i^2 xor b_i*c_i, registered per domain.
  - Cross terms, each registered individually:
    - P12 = b1*c2 xor r0, P21 = b2*c1 xor r0
    - P13 = b1*c3 xor r1, P31 = b3*c1 xor r1
    - P23 = b2*c3 xor r2, P32 = b3*c2 xor r2
  - b_i, c_i are copied into stage-1 registers.
  - v1 <= in_valid.
- Stage 2 (registered when en=1):
  - d1 <= L1 xor P12 xor P13.
  - d2 <= L2 xor P21 xor P23.
  - d3 <= L3 xor P31 xor P32.
  - b/c outputs <= stage-1 copies.
  - out_valid <= v1.
- Latency and throughput:
  - Latency is exactly 2 en-cycles.
  - Throughput is one operation per cycle.
  - Correctness: d1^d2^d3 = NU*b^2 ^ b*c ^ c^2, where b^c is formed from the unmasked byte x1^x2^x3.
- en=0:
  - Every register, including the valid bits, holds.
  - Inputs are ignored; the randomness is not consumed.
- in_valid=0 with en=1:
  - Datapath registers still load, allowing a bubble to propagate.
  - The valid bit carries 0; output data is don't-care while out_valid=0.
- Reset:
  - Asynchronous assertion clears all data and valid registers to 0 immediately.
  - Valid bits clear, so any operation in flight mid-pipeline is discarded.
  - After synchronous release, the first valid output occurs 2 en-cycles after the first accepted input.
- Randomness: r must be fresh on every cycle where en=1 and in_valid=1. Reuse is a verification failure for the probing model, not functional.
- Back-to-back operations on consecutive cycles must not interact: there is no shared state beyond the pipeline registers.
- No glitch-carrying path may cross domains before the stage-1 register. Synthesis must preserve the registers; keep-hierarchy applies.

Test Plan:
- Reset: rst_n=0 mid-stream, with a valid input in stage 1 → all outputs 0 and out_valid=0 asynchronously; after release, no spurious out_valid.
- Single operation: x=(8'h53,0,0), r=0, in_valid=1 → 2 cycles later out_valid=1 with:
  - d1^d2^d3 = 4'h9;
  - b shares XOR to 4'h5;
  - c shares XOR to 4'h3.
- Masked boundary values:
  - x shares XOR to 8'h10, random split, random r → d=4'h8.
  - 8'h01 → d=4'h1.
  - 8'h00 → d=4'h0.
- Exhaustive functional sweep: all 256 unmasked bytes, random share splits and random r, streamed back-to-back → each d matches the reference model in order, with out_valid continuous.
- Stall: en=0 for 3 cycles with a valid operation in stage 1 → outputs and out_valid hold; the result appears after 2 total en=1 cycles; r changes during the stall have no effect.
- Bubbles: alternating in_valid 1/0 → out_valid pattern is the same sequence delayed by 2 cycles; valid results are correct.
